// File: rtl/butterfly_p2s_pkg.sv
// -----------------------------------------------------------------------------
// butterfly_p2s_pkg
// Shared definitions for the butterfly serial/parallel converters (p2s and s2p).
//   BFLY_POP_BITS       number of counter bits above the lane field that are
//                       popcounted to form the lane rotation
//   BFLY_DATA_W_DEF     default element width
//   BFLY_NUM_INPUT_DEF  default lane count
//   bfly_state_e        converter FSM states
//   bfly_lane()         rotated lane for a serial element index
// -----------------------------------------------------------------------------
package butterfly_p2s_pkg;

  localparam int unsigned BFLY_POP_BITS      = 8;
  localparam int          BFLY_DATA_W_DEF    = 16;
  localparam int          BFLY_NUM_INPUT_DEF = 8;

  typedef enum logic {
    BFLY_IDLE   = 1'b0,
    BFLY_STREAM = 1'b1
  } bfly_state_e;

  // lane = (idx[lb-1:0] + popcount(idx[lb+7:lb])) mod 2^lb.
  // Index bits at or above 32 count as zero. Result is returned in 8 bits
  // with everything above bit lb-1 cleared; lb ranges 1..8.
  function automatic logic [7:0] bfly_lane(input logic [31:0] idx,
                                           input int unsigned lb);
    logic [7:0] pop;
    logic [7:0] mask;
    pop = 8'd0;
    for (int unsigned i = 0; i < BFLY_POP_BITS; i++) begin
      if (lb + i < 32) pop = pop + {7'd0, idx[5'(lb + i)]};
    end
    mask = 8'((9'd1 << lb) - 9'd1);
    return (idx[7:0] + pop) & mask;
  endfunction

endpackage

// File: rtl/butterfly_lane_idx.sv
// -----------------------------------------------------------------------------
// butterfly_lane_idx
// Combinational butterfly lane rotation: popcount of the 8 counter bits above
// the lane field, added to the low lane field, modulo 2^LB. Single shared
// definition for both conversion directions.
// Ports:
//   idx_i   [31:0]   serial element counter
//   lane_o  [LB-1:0] rotated lane index
// -----------------------------------------------------------------------------
module butterfly_lane_idx
  import butterfly_p2s_pkg::*;
#(
  parameter int LB = 3
) (
  input  logic [31:0]   idx_i,
  output logic [LB-1:0] lane_o
);

  assign lane_o = LB'(bfly_lane(idx_i, LB));

endmodule

// File: rtl/butterfly_p2s.sv
// -----------------------------------------------------------------------------
// butterfly_p2s
// Parallel-to-serial converter. Accepts one num_input-lane word and emits its
// lanes one per beat in butterfly (rotated) lane order, so that the matching
// s2p stage with the same frame length reconstructs the original words.
// Full backpressure on the serial side; no bubble between back-to-back words.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset; release synchronised to clk
//   up_dat  parallel word, lane i at [data_width*i +: data_width]
//   up_vld  up_dat valid
//   up_rdy  word can be accepted this cycle
//   length  frame length in serial elements (0 = wrap at 2^32), sampled
//           when a word is accepted with the serial counter at 0
//   dn_dat  serial element
//   dn_vld  dn_dat valid
//   dn_rdy  downstream accepts dn_dat
//   dn_last final element of a frame (only with BUTTERFLY_P2S_LAST_EN)
//
// Build option: define BUTTERFLY_P2S_LAST_EN to add the dn_last output.
// -----------------------------------------------------------------------------
module butterfly_p2s
  import butterfly_p2s_pkg::*;
#(
  parameter int data_width = BFLY_DATA_W_DEF,
  parameter int num_input  = BFLY_NUM_INPUT_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [num_input*data_width-1:0] up_dat,
  input  logic                            up_vld,
  output logic                            up_rdy,
  input  logic [31:0]                     length,
  output logic [data_width-1:0]           dn_dat,
  output logic                            dn_vld,
  input  logic                            dn_rdy
`ifdef BUTTERFLY_P2S_LAST_EN
  ,
  output logic                            dn_last
`endif
);

  localparam int LB = $clog2(num_input);

  bfly_state_e           state_q, state_d;
  logic [LB-1:0]         b_q, b_d;
  logic [31:0]           c_q, c_d;
  logic [31:0]           len_q, len_d;
  logic [data_width-1:0] buf_q [num_input];
  logic                  load;
  logic                  rst_hold_q;

  logic [LB-1:0]         lane;
  logic                  last_beat;
  logic                  c_wrap;
  logic [31:0]           c_inc;
  logic                  up_rdy_c;
  logic                  dn_vld_c;

  // Reset asserts asynchronously; this flag keeps the block from accepting
  // until the first clock edge after rst falls, so release is synchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_hold_q <= 1'b1;
    else     rst_hold_q <= 1'b0;
  end

  butterfly_lane_idx #(
    .LB(LB)
  ) u_lane_idx (
    .idx_i (c_q),
    .lane_o(lane)
  );

  assign last_beat = (b_q == LB'(num_input - 1));
  // len_q == 0 gives len_q-1 == all ones, so the counter wraps only at 2^32.
  assign c_wrap    = (c_q == len_q - 32'd1);
  assign c_inc     = c_wrap ? 32'd0 : c_q + 32'd1;

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    c_d      = c_q;
    len_d    = len_q;
    load     = 1'b0;
    up_rdy_c = 1'b0;
    dn_vld_c = 1'b0;
    case (state_q)
      BFLY_IDLE: begin
        up_rdy_c = !rst_hold_q;
        if (up_vld && up_rdy_c) begin
          load    = 1'b1;
          b_d     = '0;
          state_d = BFLY_STREAM;
          if (c_q == 32'd0) len_d = length;
        end
      end
      BFLY_STREAM: begin
        dn_vld_c = 1'b1;
        // On the last beat the next word can be taken in the same cycle the
        // final element leaves, keeping the stream gapless.
        if (last_beat) up_rdy_c = dn_rdy && !rst_hold_q;
        if (dn_rdy) begin
          b_d = b_q + LB'(1);
          c_d = c_inc;
          if (last_beat) begin
            if (up_vld && up_rdy_c) begin
              load = 1'b1;
              b_d  = '0;
              if (c_inc == 32'd0) len_d = length;
            end else begin
              state_d = BFLY_IDLE;
            end
          end
        end
      end
      default: state_d = BFLY_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BFLY_IDLE;
      b_q     <= '0;
      c_q     <= '0;
      len_q   <= '0;
      for (int i = 0; i < num_input; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      c_q     <= c_d;
      len_q   <= len_d;
      if (load) begin
        for (int i = 0; i < num_input; i++)
          buf_q[i] <= up_dat[data_width*i +: data_width];
      end
    end
  end

  assign up_rdy = up_rdy_c;
  assign dn_vld = dn_vld_c;
  // Driven only by registered state, so it holds under backpressure.
  assign dn_dat = buf_q[lane];

`ifdef BUTTERFLY_P2S_LAST_EN
  assign dn_last = dn_vld_c && c_wrap;
`endif

endmodule

// File: doc/butterfly_p2s.md
Name: butterfly_p2s

Overview:
- Parallel-to-serial converter: the transmit-side counterpart of the butterfly serial-to-parallel stage.
- Accepts one num_input-lane word and emits its lanes one per beat, in butterfly (rotated) lane order.
- Feeding its output stream into the s2p stage with the same length reproduces the original words.
- Sits between the butterfly compute array output and serial consumers (DMA / next-layer stream).

Parameters:
- data_width, 16, bits per element.
- num_input, 8, lanes per parallel word; power of two, 2..256.
- LB (localparam), $clog2(num_input), lane index width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, asynchronous assert, active-high; internal release synchronised to clk.
- up_dat  in  num_input*data_width  parallel word; lane i at bits [data_width*i +: data_width].
- up_vld  in  1  up_dat valid.
- up_rdy  out  1  block can accept a word this cycle.
- length  in  32  frame length in serial elements; sampled at frame start.
- dn_dat  out  data_width  serial element.
- dn_vld  out  1  dn_dat valid.
- dn_rdy  in  1  downstream accepts dn_dat.

Behaviour:
- Handshakes: up accepts when up_vld & up_rdy; dn transfers when dn_vld & dn_rdy.
  - dn_dat and dn_vld hold stable while dn_vld & !dn_rdy (full backpressure, unlike the s2p stage).
- State:
  - N-lane buffer buf[].
  - beat counter b (LB bits).
  - serial counter c (32 bits).
  - len_r (32 bits).
  - FSM {IDLE, STREAM}.
- Reset (async, any time incl. mid-word): state=IDLE, b=0, c=0, len_r=0, buf=0, dn_vld=0, up_rdy=0 while rst high. A partially sent word is discarded.
- IDLE:
  - up_rdy=1.
  - On accept: buf<=up_dat, b<=0, go STREAM.
  - If c==0, len_r<=length.
- STREAM:
  - dn_vld=1.
  - dn_dat = buf[lane] with lane = (c[LB-1:0] + popcount(c[LB+7:LB])) mod 2^LB.
  - Bits of c above index 31 are treated as 0.
  - On each dn transfer:
    - b<=b+1.
    - c<=(c==len_r-1) ? 0 : c+1.
  - When len_r==0: c wraps only at 2^32.
- Last beat (b==num_input-1):
  - up_rdy = dn_rdy (combinational); no bubble between words.
  - On dn transfer with a simultaneous up accept: load the new buf, b<=0, stay in STREAM.
  - Apply the len_r sample rule if the new c is 0.
  - On dn transfer without an up accept: go IDLE.
- up_rdy=0 on non-last beats of STREAM.
- Latency: word accepted at cycle t → first dn_vld at t+1. Back-to-back throughput is 1 element/cycle.
- Frame wrap mid-word (length not a multiple of num_input):
  - c restarts at 0 within the word.
  - b continues.
  - Lane order resumes from rotation 0.
  - len_r resamples only at the next word accept with c==0.
- length changes mid-frame have no effect until the frame wraps.

Optional Feature:
- Macro: BUTTERFLY_P2S_LAST_EN.
- Defined:
  - Adds output dn_last (1 bit), asserted with dn_vld when c==len_r-1, i.e. the final element of a frame.
  - Reset value 0.
  - Held stable under backpressure.
- Undefined: port absent; no other behavioural change.

Decomposition:
- Shared package (also used by butterfly_s2p):
  - BFLY_POP_BITS=8 (high-index bits counted).
  - Function bfly_lane(idx, LB) returning the rotated lane.
  - Default data_width and lane-count constants.
- One sub-module: butterfly_lane_idx, a combinational popcount+add mod 2^LB.
  - Instantiated here.
  - Intended to replace the inline s2p expression so both directions share one definition.
- FSM, counters and buffer stay in butterfly_p2s.

Test Plan:
- Reset/idle:
  - Stimulus: rst high 3 cycles, no traffic.
  - Required: dn_vld=0, up_rdy=0 during reset; up_rdy=1 the cycle after release.
- First two words (N=8, length=64):
  - Stimulus: word0 lanes = 0..7, then word1 lanes = 10..17, dn_rdy=1.
  - Required for word0: dn_dat 0,1,..,7.
  - Required for word1: 11,12,..,17,10 (c=8 → rotation 1).
  - No bubble between the two words.
- Backpressure:
  - Stimulus: dn_rdy low for 5 cycles at beat 3.
  - Required: dn_dat held at the beat-3 value, up_rdy=0, b unchanged; the sequence resumes intact.
- Frame wrap:
  - Stimulus: length=16, three words.
  - Required: word2 (c=0 again) emits lanes in order 0..7.
  - Required with BUTTERFLY_P2S_LAST_EN: dn_last on the 16th beat only.
- Round trip:
  - Stimulus: 32 random words, length=256, random dn_rdy, output looped into butterfly_s2p.
  - Required: s2p output equals the input words.
- Reset mid-word:
  - Stimulus: assert rst at beat 4.
  - Required: dn_vld drops immediately (async); after release, the next word restarts at c=0 with lane order 0..7.
